// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, driving a
// 1-cycle-latency single-port SRAM; byte stores are read-modify-write.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_READ_WAIT,
    S_WRITE,
    S_RESP,
    S_ERR_RSP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_write;
  logic                  r_word;
  logic [1:0]            r_lane;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_error;

  logic        w_ready;
  logic        w_en;
  logic        w_we;
  logic        w_rsp_valid;
  logic        w_accept;
  logic        w_addr_oor;
  logic        w_req_err;
  logic [7:0]  w_lane_byte;
  logic [31:0] w_merged;
  logic [31:0] w_load_data;

  // Any address bit above the SRAM's byte range makes the request an error.
  assign w_addr_oor = (req_addr >> (ADDR_WIDTH + 2)) != '0;
  assign w_req_err  = req_size[0]
                    | (req_size[1] & (req_addr[1:0] != 2'b00))
                    | w_addr_oor;

  assign req_ready  = w_ready & ~reset;
  assign sram_en    = w_en & ~reset;
  assign sram_we    = w_we & ~reset;
  assign rsp_valid  = w_rsp_valid & ~reset;
  assign w_accept   = req_valid & req_ready;

  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_error  = r_rsp_error;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;

  assign w_lane_byte = sram_rdata[{r_lane, 3'b000} +: 8];
  assign w_load_data = r_word ? sram_rdata : {24'b0, w_lane_byte};

  always_comb begin
    w_merged = sram_rdata;
    w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                    w_next = S_ERR_RSP;
          else if (req_write && req_size[1]) w_next = S_WRITE;
          else                              w_next = S_READ;
        end
      end
      S_READ: begin
        w_en   = 1'b1;
        w_next = S_READ_WAIT;
      end
      S_READ_WAIT: w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE: begin
        w_en   = 1'b1;
        w_we   = 1'b1;
        w_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      S_ERR_RSP: begin
        w_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Response fields change only on the edge entering RESP/ERR_RSP, so they
  // stay stable between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write     <= 1'b0;
      r_word      <= 1'b0;
      r_lane      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_word  <= req_size[1];
            r_lane  <= req_addr[1:0];
            r_addr  <= req_addr[ADDR_WIDTH+1:2];
            r_wdata <= req_wdata;
            if (w_req_err) begin
              r_rsp_rdata <= '0;
              r_rsp_error <= 1'b1;
            end
          end
        end
        S_READ_WAIT: begin
          if (r_write) begin
            r_wdata <= w_merged;
          end else begin
            r_rsp_rdata <= w_load_data;
            r_rsp_error <= 1'b0;
          end
        end
        S_WRITE: begin
          r_rsp_rdata <= '0;
          r_rsp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: behavioural SRAM, directed vector table, reset and
// back-to-back sequences, then random requests against a word-array model.
module tb_dmem_responder;

  localparam int unsigned AW    = 13;
  localparam int unsigned WORDS = 8192;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  dmem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  int en_cnt  = 0;
  int we_cnt  = 0;
  int rsp_cnt = 0;
  int cyc_n   = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    if (sram_en)            en_cnt++;
    if (sram_en && sram_we) we_cnt++;
    if (rsp_valid)          rsp_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a plain array of words, little-endian byte lanes.
  function automatic void model(input logic w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic er,
                                output int lat);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] word;
    er = (sz == 2'd1) || (sz == 2'd3) || (sz == 2'd2 && a % 4 != 0) ||
         (a >= 32'h0000_8000);
    rd = 32'h0;
    if (er) begin
      lat = 1;
      return;
    end
    idx  = a / 4;
    sh   = 8 * (a % 4);
    word = ref_mem[idx];
    if (w) begin
      if (sz == 2'd2) begin
        ref_mem[idx] = d;
        lat = 2;
      end else begin
        ref_mem[idx] = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        lat = 4;
      end
    end else begin
      rd  = (sz == 2'd2) ? word : ((word >> sh) & 32'hFF);
      lat = 3;
    end
  endfunction

  // Issues one request at posedge+1 and returns the response and its latency
  // counted from the accept cycle.
  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    bit acc;
    bit got;
    int t;
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    acc = 0;
    t   = 0;
    while (!acc && t < 20) begin
      @(negedge clk);
      if (req_ready) acc = 1;
      @(posedge clk); #1;
      t++;
    end
    req_valid = 1'b0;
    chk("accept_timeout", {31'b0, acc}, 32'd1);
    rd  = 32'hX;
    er  = 1'bX;
    lat = 1;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        rd  = rsp_rdata;
        er  = rsp_error;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("rsp_timeout", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_checked(input string nm, input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat, elat, e0, w0;
    e0 = en_cnt;
    w0 = we_cnt;
    do_req(w, sz, a, d, rd, er, lat);
    model(w, sz, a, d, erd, eer, elat);
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_err"}, {31'b0, er}, {31'b0, eer});
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_en"}, en_cnt - e0, eer ? 0 : (w && sz == 2'd0) ? 2 : 1);
    chk({nm, "_we"}, we_cnt - w0, (w && !eer) ? 1 : 0);
    if (w && !eer) chk({nm, "_mem"}, mem[a / 4], ref_mem[a / 4]);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat, mlat, e0, w0, r0, t, rdy_low, r;
    bit          ok;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];
    int          acc_cyc  [3];
    logic [31:0] bq [$];
    logic        rw;
    logic [1:0]  rsz;
    logic [31:0] ra, rdat;

    for (int i = 0; i < int'(WORDS); i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end

    tbl[0]  = '{1'b1, 2'd2, 32'h0000_0010, 32'hDEADBEEF, 32'h0,         1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,        32'hDEADBEEF,  1'b0, 3};
    tbl[2]  = '{1'b1, 2'd2, 32'h0000_0010, 32'h11223344, 32'h0,         1'b0, 2};
    tbl[3]  = '{1'b1, 2'd0, 32'h0000_0012, 32'h0000_00AB, 32'h0,        1'b0, 4};
    tbl[4]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,        32'h11AB3344,  1'b0, 3};
    tbl[5]  = '{1'b0, 2'd0, 32'h0000_0013, 32'h0,        32'h0000_0011, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'd0, 32'h0000_0012, 32'h0,        32'h0000_00AB, 1'b0, 3};
    tbl[7]  = '{1'b0, 2'd2, 32'h0000_0006, 32'h0,        32'h0,         1'b1, 1};
    tbl[8]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0,        32'h0,         1'b1, 1};
    tbl[9]  = '{1'b1, 2'd2, 32'h0000_8000, 32'h12345678, 32'h0,         1'b1, 1};
    tbl[10] = '{1'b1, 2'd3, 32'h0000_0004, 32'h0,        32'h0,         1'b1, 1};
    tbl[11] = '{1'b0, 2'd0, 32'h8000_0001, 32'h0,        32'h0,         1'b1, 1};
    tbl[12] = '{1'b1, 2'd0, 32'h0000_7FFF, 32'hFFFF_FF5A, 32'h0,        1'b0, 4};
    tbl[13] = '{1'b0, 2'd2, 32'h0000_7FFC, 32'h0,        32'h5A00_0000, 1'b0, 3};
    tbl[14] = '{1'b1, 2'd2, 32'h0000_7FFC, 32'h01020304, 32'h0,         1'b0, 2};
    tbl[15] = '{1'b0, 2'd0, 32'h0000_7FFD, 32'h0,        32'h0000_0003, 1'b0, 3};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd0);
    chk("reset_en",    {31'b0, sram_en},   32'd0);
    chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'b0, req_ready}, 32'd1);
    chk("post_reset_rdata", rsp_rdata, 32'h0);
    chk("post_reset_error", {31'b0, rsp_error}, 32'd0);
    chk("post_reset_addr",  {19'b0, sram_addr}, 32'h0);
    chk("post_reset_wdata", sram_wdata, 32'h0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      e0 = en_cnt;
      w0 = we_cnt;
      do_req(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, rd, er, lat);
      model(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, mrd, mer, mlat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      if (tbl[i].er) chk($sformatf("vec%0d_no_strobe", i), en_cnt - e0, 0);
      else           chk($sformatf("vec%0d_we", i), we_cnt - w0, tbl[i].w ? 1 : 0);
      if (i == 0) chk("word4_after_sw", mem[4], 32'hDEADBEEF);
      if (i == 3) chk("word4_after_sb", mem[4], 32'h11AB3344);
    end

    // Reset landing in READ_WAIT of a byte store must abandon the RMW.
    run_checked("fill_w2", 1'b1, 2'd2, 32'h8, 32'hFFFF_FFFF);
    w0 = we_cnt;
    r0 = rsp_cnt;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h8;
    req_wdata = 32'h0;
    @(negedge clk);
    chk("rmw_reset_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rmw_reset_ready", {31'b0, req_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("rmw_reset_no_we",  we_cnt - w0, 0);
    chk("rmw_reset_no_rsp", rsp_cnt - r0, 0);
    chk("rmw_reset_w2",     mem[2], 32'hFFFF_FFFF);
    run_checked("rmw_reset_load", 1'b0, 2'd2, 32'h8, 32'h0);

    // Three word loads with req_valid held high throughout.
    b2b_addr[0] = 32'h10;
    b2b_addr[1] = 32'h7FFC;
    b2b_addr[2] = 32'h8;
    for (int k = 0; k < 3; k++) model(1'b0, 2'd2, b2b_addr[k], 32'h0, b2b_exp[k], mer, mlat);
    rdy_low   = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    for (int k = 0; k < 3; k++) begin
      req_addr = b2b_addr[k];
      ok = 0;
      t  = 0;
      while (!ok && t < 20) begin
        @(negedge clk);
        if (rsp_valid) bq.push_back(rsp_rdata);
        if (req_ready) begin
          ok = 1;
          acc_cyc[k] = cyc_n;
        end else begin
          rdy_low++;
        end
        @(posedge clk); #1;
        t++;
      end
      chk($sformatf("b2b_accept%0d", k), {31'b0, ok}, 32'd1);
    end
    req_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) bq.push_back(rsp_rdata);
      @(posedge clk); #1;
    end
    chk("b2b_spacing1", acc_cyc[1] - acc_cyc[0], 4);
    chk("b2b_spacing2", acc_cyc[2] - acc_cyc[0], 8);
    chk("b2b_ready_low", rdy_low, 6);
    chk("b2b_rsp_count", bq.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < bq.size()) chk($sformatf("b2b_data%0d", k), bq[k], b2b_exp[k]);

    for (int n = 0; n < 80; n++) begin
      rw  = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 5));
      rsz = (r < 2) ? 2'd0 : (r < 4) ? 2'd2 : (r == 4) ? 2'd1 : 2'd3;
      ra  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(15, 31));
      rdat = $urandom;
      run_checked($sformatf("rnd%0d", n), rw, rsz, ra, rdat);
    end

    for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
    chk("final_mem_top", mem[WORDS-1], ref_mem[WORDS-1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
